// File: rtl/contador_multicanal_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the multi-channel handshake counter:
//   arb_state_t    arbiter state (idle / calculating)
//   DIR_UP/DOWN    encoding of the per-channel direction input
//   clog2()        index width helper, never narrower than 1 bit
// -----------------------------------------------------------------------------
package contador_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_CALC = 1'b1
  } arb_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Width needed to index n items; a single channel still gets a 1-bit index.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/contador_multicanal_if.sv
// -----------------------------------------------------------------------------
// contador_multicanal_if
// Bundle of the NUM_CH 4-phase sync/ack channels between the master
// controllers and the counter.
//   sync      master -> slave  per-channel request
//   down      master -> slave  per-channel direction (1 = subtract)
//   step      master -> slave  per-channel step, slice i = [i*STEP_WIDTH +: STEP_WIDTH]
//   data_in   master -> slave  per-channel operand, slice i as for step
//   ack       slave -> master  per-channel acknowledge
//   data_out  slave -> master  per-channel registered result
//   ovf       slave -> master  per-channel overflow/underflow of the last result
// -----------------------------------------------------------------------------
interface contador_multicanal_if #(
  parameter int NUM_CH     = 4,
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int STEP_WIDTH = 8
);

  logic [NUM_CH-1:0]            sync;
  logic [NUM_CH-1:0]            down;
  logic [NUM_CH*STEP_WIDTH-1:0] step;
  logic [NUM_CH*IN_WIDTH-1:0]   data_in;
  logic [NUM_CH-1:0]            ack;
  logic [NUM_CH*OUT_WIDTH-1:0]  data_out;
  logic [NUM_CH-1:0]            ovf;

  modport master (
    output sync, down, step, data_in,
    input  ack, data_out, ovf
  );

  modport slave (
    input  sync, down, step, data_in,
    output ack, data_out, ovf
  );

endinterface

// File: rtl/contador_multicanal_arbitro_rr.sv
// -----------------------------------------------------------------------------
// arbitro_rr
// Combinational round-robin selector: picks the first requesting channel at or
// after the pointer, wrapping modulo NUM_CH.
//   req      in   NUM_CH  request vector
//   ptr      in   PTR_W   channel with highest priority (must be < NUM_CH)
//   gnt      out  NUM_CH  one-hot grant (all zero when nothing requests)
//   idx      out  PTR_W   binary index of the granted channel
//   any_req  out  1       at least one request is present
// -----------------------------------------------------------------------------
module arbitro_rr
  import contador_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  idx,
  output logic              any_req
);

  int j;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves it holding a value (no latch).
    gnt     = '0;
    idx     = '0;
    any_req = |req;
    j       = 0;
    // Walk the ring from the farthest offset back to the pointer: the
    // requester closest to the pointer is written last and therefore wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_CH;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/contador_multicanal.sv
// -----------------------------------------------------------------------------
// contador_multicanal
// NUM_CH independent 4-phase sync/ack slave channels sharing one registered
// add/subtract unit through a round-robin arbiter. Each grant takes two edges:
// the IDLE edge captures the channel's operands, the CALC edge writes its
// result and raises its ack.
//   clock    in   1      system clock, rising edge
//   reset_n  in   1      asynchronous active-low reset
//   bus      slave       sync/down/step/data_in in, ack/data_out/ovf out
// Parameters: NUM_CH, IN_WIDTH, OUT_WIDTH, STEP_WIDTH, SATURATE (0 wrap, 1 clamp)
// -----------------------------------------------------------------------------
module contador_multicanal
  import contador_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int STEP_WIDTH = 8,
  parameter int SATURATE   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  contador_multicanal_if.slave  bus
);

  localparam int PTR_W  = clog2(NUM_CH);
  localparam int IO_MAX = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  // One spare bit above the widest operand holds the carry of the add; the
  // step is included so an unusually wide step is never truncated.
  localparam int CW     = ((IO_MAX > STEP_WIDTH) ? IO_MAX : STEP_WIDTH) + 1;

  // Per-channel views of the flattened operand buses.
  logic [NUM_CH-1:0][STEP_WIDTH-1:0] step_v;
  logic [NUM_CH-1:0][IN_WIDTH-1:0]   data_in_v;

  assign step_v    = bus.step;
  assign data_in_v = bus.data_in;

  // Arbiter state and captured operands of the granted channel.
  arb_state_t             state;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       gidx;
  logic [NUM_CH-1:0]      gnt_q;
  logic                   g_down;
  logic [STEP_WIDTH-1:0]  g_step;
  logic [IN_WIDTH-1:0]    g_data;

  // Per-channel outputs.
  logic [NUM_CH-1:0]                ack_q;
  logic [NUM_CH-1:0]                ovf_q;
  logic [NUM_CH-1:0][OUT_WIDTH-1:0] data_q;

  // Arbiter interface.
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] arb_gnt;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_any;

  // A channel may be granted while it requests, has not been acknowledged yet
  // and is not the one currently being calculated.
  assign eligible = bus.sync & ~ack_q & ((state == ARB_CALC) ? ~gnt_q : '1);

  arbitro_rr #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arbitro (
    .req     (eligible),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  // ---------------------------------------------------------------------------
  // Arbiter FSM: IDLE grants and captures operands, CALC hands the result over
  // and advances the pointer past the channel just served.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples values from before the edge regardless of order.
    if (!reset_n) begin
      state  <= ARB_IDLE;
      ptr    <= '0;
      gidx   <= '0;
      gnt_q  <= '0;
      g_down <= DIR_UP;
      g_step <= '0;
      g_data <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (arb_any) begin
            gidx   <= arb_idx;
            gnt_q  <= arb_gnt;
            g_down <= bus.down[arb_idx];
            g_step <= step_v[arb_idx];
            g_data <= data_in_v[arb_idx];
            state  <= ARB_CALC;
          end
        end
        ARB_CALC: begin
          if (gidx == PTR_W'(NUM_CH - 1)) ptr <= '0;
          else                            ptr <= gidx + 1'b1;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shared add/subtract unit working on the captured operands.
  // ---------------------------------------------------------------------------
  logic [CW-1:0]        op_a;
  logic [CW-1:0]        op_b;
  logic [CW-1:0]        res;
  logic                 under;
  logic                 over;
  logic                 res_ovf;
  logic [OUT_WIDTH-1:0] res_out;

  always_comb begin
    op_a  = CW'(g_data);
    op_b  = CW'(g_step);
    under = (g_down == DIR_DOWN) && (op_a < op_b);
    res   = (g_down == DIR_DOWN) ? (op_a - op_b) : (op_a + op_b);
    // Any bit above the output width means the true result does not fit.
    over    = !under && ((res >> OUT_WIDTH) != '0);
    res_ovf = under | over;
    // Wrapping keeps the low bits; on underflow these are the two's-complement
    // residue, which is exactly the modulo-2^OUT_WIDTH result.
    res_out = res[OUT_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (over)  res_out = '1;
      if (under) res_out = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel ack, result and flag registers. Release (ack & ~sync) runs on
  // every channel each edge; the CALC completion sets the granted channel's ack
  // even if its sync already fell, which then clears on the following edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_q  <= '0;
      ovf_q  <= '0;
      // NOTE: the result array is a set of visible output registers, not a
      // storage RAM, so it is reset along with the rest of the state.
      data_q <= '0;
    end else begin
      ack_q <= (ack_q & bus.sync) | ((state == ARB_CALC) ? gnt_q : '0);
      if (state == ARB_CALC) begin
        data_q[gidx] <= res_out;
        ovf_q[gidx]  <= res_ovf;
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.ovf      = ovf_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_contador_multicanal.sv
// -----------------------------------------------------------------------------
// tb_contador_multicanal
// Two 4-channel counters (8-bit results, 12-bit operands) share one stimulus:
// one wraps, one saturates. A third, single-channel 32-bit instance covers the
// legacy +1 behaviour. Inputs change and outputs are sampled on the falling
// edge; the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_contador_multicanal;

  localparam int NCH  = 4;
  localparam int INW  = 12;
  localparam int OUTW = 8;
  localparam int STW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  contador_multicanal_if #(.NUM_CH(NCH), .IN_WIDTH(INW), .OUT_WIDTH(OUTW), .STEP_WIDTH(STW)) ifa ();
  contador_multicanal_if #(.NUM_CH(NCH), .IN_WIDTH(INW), .OUT_WIDTH(OUTW), .STEP_WIDTH(STW)) ifb ();
  contador_multicanal_if #(.NUM_CH(1), .IN_WIDTH(32), .OUT_WIDTH(32), .STEP_WIDTH(8)) ifc ();

  // The saturating instance sees exactly the same requests as the wrapping one.
  assign ifb.sync    = ifa.sync;
  assign ifb.down    = ifa.down;
  assign ifb.step    = ifa.step;
  assign ifb.data_in = ifa.data_in;

  contador_multicanal #(
    .NUM_CH(NCH), .IN_WIDTH(INW), .OUT_WIDTH(OUTW), .STEP_WIDTH(STW), .SATURATE(0)
  ) dut_wrap (.clock(clk), .reset_n(rst_n), .bus(ifa));

  contador_multicanal #(
    .NUM_CH(NCH), .IN_WIDTH(INW), .OUT_WIDTH(OUTW), .STEP_WIDTH(STW), .SATURATE(1)
  ) dut_sat (.clock(clk), .reset_n(rst_n), .bus(ifb));

  contador_multicanal #(
    .NUM_CH(1), .IN_WIDTH(32), .OUT_WIDTH(32), .STEP_WIDTH(8), .SATURATE(0)
  ) dut_one (.clock(clk), .reset_n(rst_n), .bus(ifc));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit dn;
    int s;
    int d;
    int ew;  // expected result, wrapping instance
    bit ow;
    int es;  // expected result, saturating instance
    bit os;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference arithmetic straight from the rules: exact integer result, then
  // range test against 0..255.
  function automatic void model(input bit dn, input int s, input int d, input bit sat,
                                output int out, output bit ov);
    int r;
    r  = dn ? d - s : d + s;
    ov = (r < 0) || (r > 255);
    if (!ov)     out = r;
    else if (sat) out = (r < 0) ? 0 : 255;
    else         out = r & 255;
  endfunction

  function automatic int out_of(input bit sat, input int ch);
    return sat ? int'(ifb.data_out[ch*OUTW +: OUTW]) : int'(ifa.data_out[ch*OUTW +: OUTW]);
  endfunction

  function automatic int ovf_of(input bit sat, input int ch);
    return sat ? int'(ifb.ovf[ch]) : int'(ifa.ovf[ch]);
  endfunction

  task automatic set_ch(input int ch, input bit dn, input int s, input int d);
    ifa.down[ch]              = dn;
    ifa.step[ch*STW +: STW]   = STW'(s);
    ifa.data_in[ch*INW +: INW] = INW'(d);
  endtask

  task automatic wait_ack(input int ch, input bit val, input int budget, input string name,
                          output int edges);
    edges = 0;
    while (ifa.ack[ch] !== val && edges < budget) begin
      @(negedge clk);
      edges++;
    end
    check({name, "_ack"}, ifa.ack[ch], val);
  endtask

  // One uncontended transaction with hold and release checks.
  task automatic do_txn(input string name, input int ch, input vec_t v);
    int lat;
    set_ch(ch, v.dn, v.s, v.d);
    ifa.sync[ch] = 1'b1;
    wait_ack(ch, 1'b1, 12, name, lat);
    check({name, "_lat"}, lat, 2);
    check({name, "_ack_sat"}, ifb.ack[ch], 1);
    check({name, "_out_wrap"}, out_of(0, ch), v.ew);
    check({name, "_ovf_wrap"}, ovf_of(0, ch), v.ow);
    check({name, "_out_sat"}, out_of(1, ch), v.es);
    check({name, "_ovf_sat"}, ovf_of(1, ch), v.os);
    @(negedge clk);
    check({name, "_hold_ack"}, ifa.ack[ch], 1);
    check({name, "_hold_out"}, out_of(0, ch), v.ew);
    ifa.sync[ch] = 1'b0;
    @(negedge clk);
    check({name, "_release"}, ifa.ack[ch], 0);
  endtask

  // All channels request on the same edge with the pointer at 0.
  task automatic contention(input string name, input int base);
    int rise[NCH];
    for (int k = 0; k < NCH; k++) begin
      set_ch(k, 1'b0, k + 1, base + k);
      rise[k] = 0;
    end
    ifa.sync = '1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++)
        if (ifa.ack[k] && rise[k] == 0) rise[k] = e;
    end
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("%s_rise_ch%0d", name, k), rise[k], 2 * (k + 1));
      check($sformatf("%s_out_ch%0d", name, k), out_of(0, k), base + 2 * k + 1);
      check($sformatf("%s_sat_ch%0d", name, k), out_of(1, k), base + 2 * k + 1);
      check($sformatf("%s_ovf_ch%0d", name, k), ovf_of(0, k), 0);
    end
    ifa.sync = '0;
    @(negedge clk);
    check({name, "_release_all"}, ifa.ack, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int e;
    vec_t v;

    vecs[0] = '{1'b0,   1,   41,  42, 1'b0,  42, 1'b0};
    vecs[1] = '{1'b0,  10,  250,   4, 1'b1, 255, 1'b1};
    vecs[2] = '{1'b1,   5,    3, 254, 1'b1,   0, 1'b1};
    vecs[3] = '{1'b0,   0,  255, 255, 1'b0, 255, 1'b0};
    vecs[4] = '{1'b1,   0,    0,   0, 1'b0,   0, 1'b0};
    vecs[5] = '{1'b0,  10,  245, 255, 1'b0, 255, 1'b0};
    vecs[6] = '{1'b1,  10,   10,   0, 1'b0,   0, 1'b0};
    vecs[7] = '{1'b0,   1,  300,  45, 1'b1, 255, 1'b1};
    vecs[8] = '{1'b1, 255, 4095,   0, 1'b1, 255, 1'b1};
    vecs[9] = '{1'b1, 200,  100, 156, 1'b1,   0, 1'b1};

    ifa.sync = '0; ifa.down = '0; ifa.step = '0; ifa.data_in = '0;
    ifc.sync = '0; ifc.down = '0; ifc.step = '0; ifc.data_in = '0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ack", ifa.ack, 0);
    check("reset_ovf", ifa.ovf, 0);
    check("reset_out", ifa.data_out, 0);
    check("reset_out_one", ifc.data_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-channel legacy behaviour: 41 + 1.
    ifc.data_in = 32'd41;
    ifc.step    = 8'd1;
    ifc.down    = 1'b0;
    ifc.sync    = 1'b1;
    e = 0;
    while (ifc.ack !== 1'b1 && e < 10) begin
      @(negedge clk);
      e++;
    end
    check("one_lat", e, 2);
    check("one_out", ifc.data_out, 42);
    check("one_ovf", ifc.ovf, 0);
    ifc.sync = 1'b0;
    @(negedge clk);
    check("one_release", ifc.ack, 0);

    contention("cont1", 10);
    contention("cont2", 100);

    for (int i = 0; i < 10; i++) do_txn($sformatf("vec%0d", i), i % NCH, vecs[i]);

    // Early sync drop during CALC, with operands scrambled after the grant.
    set_ch(3, 1'b0, 10, 250);
    ifa.sync[3] = 1'b1;
    @(negedge clk);
    check("early_ack_low", ifa.ack[3], 0);
    ifa.sync[3] = 1'b0;
    set_ch(3, 1'b1, 1, 1);
    @(negedge clk);
    check("early_ack_pulse", ifa.ack[3], 1);
    check("early_out_wrap", out_of(0, 3), 4);
    check("early_ovf_wrap", ovf_of(0, 3), 1);
    check("early_out_sat", out_of(1, 3), 255);
    @(negedge clk);
    check("early_ack_clear", ifa.ack[3], 0);

    // Fairness: ch0 re-requests immediately after every release, ch2 joins.
    begin
      int  ch0_before;
      bit  ch2_req;
      bit  ch2_done;
      ch0_before = 0; ch2_req = 0; ch2_done = 0; e = 0;
      set_ch(0, 1'b0, 1, 5);
      set_ch(2, 1'b0, 2, 7);
      ifa.sync[0] = 1'b1;
      while (!ch2_done && e < 40) begin
        @(negedge clk);
        e++;
        if (ifa.ack[2] && ch2_req) ch2_done = 1'b1;
        if (ifa.ack[0] && ifa.sync[0]) begin
          if (ch2_req) ch0_before++;
          ifa.sync[0] = 1'b0;
        end else if (!ifa.ack[0] && !ifa.sync[0]) begin
          ifa.sync[0] = 1'b1;
        end
        if (e == 3 && !ch2_req) begin
          ifa.sync[2] = 1'b1;
          ch2_req     = 1'b1;
        end
      end
      check("fair_ch2_served", ch2_done, 1);
      check("fair_ch0_grants_first", ch0_before <= 1, 1);
      check("fair_ch2_out", out_of(0, 2), 9);
      ifa.sync = '0;
      repeat (3) @(negedge clk);
      check("fair_release", ifa.ack, 0);
    end

    // Asynchronous reset between edges while channel 1 is in CALC.
    set_ch(1, 1'b0, 3, 20);
    ifa.sync[1] = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_ack", ifa.ack, 0);
    check("areset_out_wrap", ifa.data_out, 0);
    check("areset_out_sat", ifb.data_out, 0);
    check("areset_ovf", ifa.ovf | ifb.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1, 1'b1, 12, "areset_reserve", lat);
    check("areset_lat", lat, 2);
    check("areset_out", out_of(0, 1), 23);
    ifa.sync[1] = 1'b0;
    @(negedge clk);
    check("areset_release", ifa.ack[1], 0);

    // Randomized concurrent traffic against the reference model. Operands are
    // held from request until ack, so the captured values are known.
    begin
      int st[NCH];
      int hold[NCH];
      int waitn[NCH];
      int rs[NCH];
      int rd[NCH];
      bit rdn[NCH];
      int n_done;
      int done_ch;
      int exp_o;
      bit exp_v;
      n_done = 0;
      for (int k = 0; k < NCH; k++) begin
        st[k] = 0; hold[k] = 0; waitn[k] = 0; rs[k] = 0; rd[k] = 0; rdn[k] = 0;
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        done_ch = -1;
        for (int k = 0; k < NCH; k++)
          if (st[k] == 1 && ifa.ack[k]) done_ch = k;
        if (done_ch >= 0) begin
          n_done++;
          for (int s = 0; s < 2; s++) begin
            model(rdn[done_ch], rs[done_ch], rd[done_ch], s[0], exp_o, exp_v);
            check($sformatf("rnd_out_s%0d_ch%0d", s, done_ch), out_of(s[0], done_ch), exp_o);
            check($sformatf("rnd_ovf_s%0d_ch%0d", s, done_ch), ovf_of(s[0], done_ch), exp_v);
          end
          // Round robin serves every other channel at most once before this one.
          check("rnd_wait_bound", waitn[done_ch] <= NCH - 1, 1);
          for (int k = 0; k < NCH; k++)
            if (st[k] == 1 && k != done_ch) waitn[k]++;
          st[done_ch]   = 2;
          hold[done_ch] = $urandom_range(2, 0);
        end
        for (int k = 0; k < NCH; k++) begin
          if (k == done_ch) continue;
          case (st[k])
            2: begin
              check("rnd_hold_ack", ifa.ack[k], 1);
              if (hold[k] == 0) begin
                ifa.sync[k] = 1'b0;
                st[k] = 3;
              end else begin
                hold[k]--;
              end
            end
            3: if (!ifa.ack[k]) st[k] = 0;
            0: if ($urandom_range(2, 0) == 0) begin
              rdn[k] = 1'($urandom_range(1, 0));
              rs[k]  = $urandom_range(255, 0);
              rd[k]  = ($urandom_range(3, 0) == 0) ? $urandom_range(299, 0)
                                                   : $urandom_range(4095, 0);
              set_ch(k, rdn[k], rs[k], rd[k]);
              ifa.sync[k] = 1'b1;
              waitn[k]    = 0;
              st[k]       = 1;
            end
            default: ;
          endcase
        end
      end
      check("rnd_enough_done", n_done > 100, 1);
      ifa.sync = '0;
      repeat (4) @(negedge clk);
      check("rnd_final_release", ifa.ack, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
